// File: rtl/mem_access_unit_pkg.sv
// Shared constants and state encodings for the readM/writeM/inputReady
// memory-bus initiator.
package mem_access_unit_pkg;

  localparam int MEM_WORD_SIZE      = 16;
  localparam int MEM_WRITE_CYCLES   = 4;
  localparam int MEM_TIMEOUT_CYCLES = 64;
  localparam int MEM_CNT_W          = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_READ    = 2'b01,
    ST_WRITE   = 2'b10,
    ST_RELEASE = 2'b11
  } mau_state_t;

endpackage

// File: rtl/mem_access_unit.sv
// Initiator side of the 16-bit readM/writeM/inputReady memory bus: one request
// at a time, one response pulse per request, strobe always returns to 0.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int WORD_SIZE      = MEM_WORD_SIZE,
  parameter int WRITE_CYCLES   = MEM_WRITE_CYCLES,
  parameter int TIMEOUT_CYCLES = MEM_TIMEOUT_CYCLES,
  parameter int CNT_W          = MEM_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [WORD_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 req_ready,
  output logic                 resp_valid,
  output logic                 resp_error,
  output logic [WORD_SIZE-1:0] resp_rdata,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  input  logic                 inputReady
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, so requests offered elsewhere are simply
  // not taken. resp_valid is a single-cycle pulse with no back-pressure.

  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mau_state_t           state;
  mau_state_t           next_state;
  logic [CNT_W-1:0]     cnt;
  logic [WORD_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] wdata_q;
  logic                 err_q;
  logic                 accept;

  assign accept = (state == ST_IDLE) && req_valid;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (req_valid) next_state = req_write ? ST_WRITE : ST_READ;
      ST_READ:    if (inputReady || (cnt == TO_LAST)) next_state = ST_RELEASE;
      ST_WRITE:   if (cnt == WR_LAST) next_state = ST_RELEASE;
      ST_RELEASE: next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Datapath: address/data latched only on acceptance, so the bus address is
  // stable for the whole strobe and the following RELEASE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt     <= '0;
            err_q   <= 1'b0;
          end
        end
        ST_READ: begin
          // Data arriving on the timeout edge still wins.
          if (inputReady)           resp_rdata <= data;
          else if (cnt == TO_LAST)  err_q      <= 1'b1;
          else                      cnt        <= cnt + 1'b1;
        end
        ST_WRITE: begin
          if (cnt != WR_LAST) cnt <= cnt + 1'b1;
        end
        ST_RELEASE: err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign req_ready  = (state == ST_IDLE);
  assign readM      = (state == ST_READ);
  assign writeM     = (state == ST_WRITE);
  assign resp_valid = (state == ST_RELEASE);
  assign resp_error = (state == ST_RELEASE) && err_q;
  assign address    = addr_q;
  assign data       = (state == ST_WRITE) ? wdata_q : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural memory responder,
// an expected-response queue and a bus monitor.
module tb_mem_access_unit;

  localparam int W      = 16;
  localparam int RD_LAT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [W-1:0]  req_addr  = '0;
  logic [W-1:0]  req_wdata = '0;
  logic          req_ready;
  logic          resp_valid;
  logic          resp_error;
  logic [W-1:0]  resp_rdata;
  logic          readM;
  logic          writeM;
  logic [W-1:0]  address;
  wire  [W-1:0]  data;
  logic          inputReady = 1'b0;

  mem_access_unit dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_error (resp_error),
    .resp_rdata (resp_rdata),
    .readM      (readM),
    .writeM     (writeM),
    .address    (address),
    .data       (data),
    .inputReady (inputReady)
  );

  // ---------------- behavioural memory ----------------
  logic [W-1:0] mem [0:4095];
  logic         mem_en    = 1'b1;
  logic         mem_drive = 1'b0;
  logic [W-1:0] mem_dout  = '0;
  int           rd_cnt    = 0;

  assign data = mem_drive ? mem_dout : {W{1'bz}};

  always @(posedge clk) begin
    if (writeM) mem[address[11:0]] = data;
    if (readM && mem_en) begin
      if (rd_cnt == RD_LAT) begin
        inputReady <= 1'b1;
        mem_dout   <= mem[address[11:0]];
        mem_drive  <= 1'b1;
      end else begin
        rd_cnt <= rd_cnt + 1;
      end
    end else begin
      inputReady <= 1'b0;
      mem_drive  <= 1'b0;
      rd_cnt     <= 0;
    end
  end

  // ---------------- scoreboard ----------------
  logic [W:0]   exp_q[$];
  logic [W-1:0] last_rdata = '0;
  logic [W-1:0] cur_wdata  = '0;
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  int low_run = 99;
  int wr_run  = 0;
  logic [W:0] exp_e;

  always @(negedge clk) begin
    if (reset) begin
      low_run = 99;
      wr_run  = 0;
    end else begin
      if (readM || writeM) begin
        check("strobe_excl", {31'd0, readM & writeM}, 32'd0);
        if (low_run != 0) check("strobe_gap", {31'd0, low_run >= 2}, 32'd1);
        low_run = 0;
      end else begin
        low_run++;
      end
      if (writeM) begin
        check("write_bus", {16'd0, data}, {16'd0, cur_wdata});
        wr_run++;
      end else if (wr_run != 0) begin
        check("write_len", wr_run, 32'd4);
        wr_run = 0;
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_resp: got err=%b rdata=%h, expected no response", resp_error, resp_rdata);
        end else begin
          exp_e = exp_q.pop_front();
          check("resp", {15'd0, resp_error, resp_rdata}, {15'd0, exp_e});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic wr, input logic [W-1:0] a, input logic [W-1:0] wd,
                       input logic push, input logic exp_err, input logic hold);
    int k;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    k = 0;
    while (!req_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) check("accept_timeout", 32'd0, 32'd1);
    if (wr) cur_wdata = wd;
    if (push) begin
      if (!wr && !exp_err) last_rdata = mem[a[11:0]];
      exp_q.push_back({exp_err, last_rdata});
    end
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("drain", exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    int n;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'h023] = 16'h6000;
    mem[12'h001] = 16'h0001;
    mem[12'h002] = 16'hFFFF;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_readM",     {31'd0, readM},     32'd0);
    check("rst_writeM",    {31'd0, writeM},    32'd0);
    check("rst_resp",      {30'd0, resp_valid, resp_error}, 32'd0);
    check("rst_rdata",     {16'd0, resp_rdata}, 32'd0);
    check("rst_address",   {16'd0, address},    32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Plain read of preloaded word
    issue(1'b0, 16'h0023, 16'h0000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("read_strobe_up", {31'd0, readM}, 32'd1);
    check("read_address", {16'd0, address}, 32'h0023);
    drain();

    // Write with exact strobe timing, then read back
    issue(1'b1, 16'h0100, 16'hBEEF, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("wr_strobe", {31'd0, writeM}, 32'd1);
      check("wr_resp_early", {31'd0, resp_valid}, 32'd0);
    end
    @(negedge clk);
    check("wr_resp_cycle5", {30'd0, resp_valid, writeM}, 32'd2);
    drain();
    issue(1'b0, 16'h0100, 16'h0000, 1'b1, 1'b0, 1'b0);
    drain();

    // Back-to-back reads with req_valid held high
    issue(1'b0, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);
    issue(1'b0, 16'h0002, 16'h0000, 1'b1, 1'b0, 1'b1);
    issue(1'b0, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);
    issue(1'b0, 16'h0002, 16'h0000, 1'b1, 1'b0, 1'b0);
    drain();

    // Read timeout: responder disabled
    mem_en = 1'b0;
    issue(1'b0, 16'h0005, 16'h0000, 1'b1, 1'b1, 1'b0);
    n = 0;
    @(negedge clk);
    while (readM && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("timeout_len", n, 32'd64);
    check("timeout_strobe_down", {31'd0, readM}, 32'd0);
    drain();
    mem_en = 1'b1;

    // Reset in the middle of a read: no response expected
    issue(1'b0, 16'h0023, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("mid_read_strobe", {31'd0, readM}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_readM",     {31'd0, readM},      32'd0);
    check("abort_req_ready", {31'd0, req_ready},  32'd1);
    check("abort_resp",      {31'd0, resp_valid}, 32'd0);
    check("abort_address",   {16'd0, address},    32'd0);
    check("abort_rdata",     {16'd0, resp_rdata}, 32'd0);
    last_rdata = '0;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    issue(1'b0, 16'h0023, 16'h0000, 1'b1, 1'b0, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
